// File: rtl/matmul_mac16.sv
// matmul_mac16: 16-lane multiply-accumulate engine producing one output row of a matrix product.
// Each enabled beat adds din lane * shared weight into a per-lane accumulator; a last-beat flag
// publishes all lane sums as one wide registered word and restarts accumulation.
// Build option: define MATMUL_SIGNED_EN to treat activations and weight as two's complement
// (products sign-extended); otherwise all operands are unsigned and zero-extended.
module matmul_mac16 #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int AW    = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                valid_i,
  input  logic                en_i,
  input  logic [LANES*DW-1:0] din_i,
  input  logic [DW-1:0]       win_i,
  output logic                vld_o,
  output logic [LANES*AW-1:0] matmul_o
);

  logic [LANES-1:0][2*DW-1:0] prod;
  logic [LANES-1:0][AW-1:0]   sum;
  logic [LANES-1:0][AW-1:0]   acc_q, acc_d;
  logic [LANES-1:0][AW-1:0]   res_q, res_d;
  logic                       vld_q, vld_d;

  // Per-lane product widened to accumulator width and added to the running sum.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef MATMUL_SIGNED_EN
      prod[i] = {{DW{din_i[DW*i+DW-1]}}, din_i[DW*i +: DW]} * {{DW{win_i[DW-1]}}, win_i};
      sum[i]  = acc_q[i] + {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
`else
      prod[i] = {{DW{1'b0}}, din_i[DW*i +: DW]} * {{DW{1'b0}}, win_i};
      sum[i]  = acc_q[i] + {{(AW-2*DW){1'b0}}, prod[i]};
`endif
    end
  end

  // A closing beat publishes the sums including this beat and clears the accumulators.
  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    vld_d = 1'b0;
    if (en_i) begin
      if (valid_i) begin
        res_d = sum;
        acc_d = '0;
        vld_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // State registers; reset discards partial sums and the published result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign vld_o    = vld_q;
  assign matmul_o = res_q;

endmodule

// File: tb/tb_matmul_mac16.sv
// tb_matmul_mac16: self-checking bench for matmul_mac16.
// Reference model keeps the beats of the open dot product in a queue and sums them at each close.
// Honours MATMUL_SIGNED_EN the same way the design does.
module tb_matmul_mac16;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int AW    = 32;

  logic                clk_i = 1'b0;
  logic                rstn_i;
  logic                valid_i;
  logic                en_i;
  logic [LANES*DW-1:0] din_i;
  logic [DW-1:0]       win_i;
  logic                vld_o;
  logic [LANES*AW-1:0] matmul_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [LANES*DW-1:0] din;
    logic [DW-1:0]       win;
  } beat_t;

  typedef struct {
    bit          en;
    bit          valid;
    logic [7:0]  win;
    logic [7:0]  l0;
    logic [7:0]  l15;
    bit          expVld;
    logic [31:0] expL0;
    logic [31:0] expL15;
  } vec_t;

  beat_t               beatQ[$];
  logic [LANES*AW-1:0] modelOut = '0;
  bit                  modelVld = 1'b0;

  matmul_mac16 #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .en_i    (en_i),
    .din_i   (din_i),
    .win_i   (win_i),
    .vld_o   (vld_o),
    .matmul_o(matmul_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] laneProd(logic [7:0] a, logic [7:0] b);
`ifdef MATMUL_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
`else
    return 32'(int'(a) * int'(b));
`endif
  endfunction

  function automatic logic [LANES*AW-1:0] dotProduct();
    logic [LANES*AW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [31:0] s;
      s = '0;
      foreach (beatQ[k]) s = s + laneProd(beatQ[k].din[8*l +: 8], beatQ[k].win);
      r[32*l +: 32] = s;
    end
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] randDin();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input bit en, input bit valid, input logic [7:0] win,
                               input logic [LANES*DW-1:0] din);
    beat_t b;
    en_i    = en;
    valid_i = valid;
    win_i   = win;
    din_i   = din;
    @(posedge clk_i);
    modelVld = 1'b0;
    if (rstn_i && en) begin
      b.din = din;
      b.win = win;
      beatQ.push_back(b);
      if (valid) begin
        modelOut = dotProduct();
        modelVld = 1'b1;
        beatQ.delete();
      end
    end
    #1;
  endtask

  task automatic applyReset();
    rstn_i = 1'b0;
    beatQ.delete();
    modelOut = '0;
    modelVld = 1'b0;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    if (vld_o !== modelVld) begin
      failures++;
      $display("[TB] FAIL %s vld_o got=%0b exp=%0b", tag, vld_o, modelVld);
    end
    checks++;
    if (matmul_o !== modelOut) begin
      failures++;
      $display("[TB] FAIL %s matmul_o got=%h exp=%h", tag, matmul_o, modelOut);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  vec_t        vecs[16];
  logic [7:0]  bytes0[8];
  logic [7:0]  bytes15[8];
  logic [31:0] maxExp;

  initial begin
    logic [LANES*DW-1:0] d;
    int pulses;

    bytes0  = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h02, 8'h04, 8'h06, 8'h08};
    bytes15 = '{8'h01, 8'h03, 8'h05, 8'h01, 8'h01, 8'h03, 8'h05, 8'h07};
    for (int k = 0; k < 16; k++) begin
      int b;
      b = k % 8;
      vecs[k].en     = 1'b1;
      vecs[k].valid  = (b == 7);
      vecs[k].win    = 8'(b + 1);
      vecs[k].l0     = bytes0[b];
      vecs[k].l15    = bytes15[b];
      vecs[k].expVld = (b == 7);
      vecs[k].expL0  = (k >= 7) ? 32'd200 : 32'd0;
      vecs[k].expL15 = (k >= 7) ? 32'd140 : 32'd0;
    end
`ifdef MATMUL_SIGNED_EN
    maxExp = 32'h0000_0001;
`else
    maxExp = 32'h0000_FE01;
`endif

    // Reset held with random inputs, then released with no enables.
    rstn_i = 1'b0; en_i = 1'b0; valid_i = 1'b0; win_i = '0; din_i = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), randDin());
      checkOutput("reset_hold");
      checkValue("reset_hold_lane0", matmul_o[31:0], 32'd0);
    end
    rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'($urandom), 8'($urandom), randDin());
      checkOutput("post_reset_idle");
    end

    // Eight-beat row followed immediately by the identical row.
    for (int k = 0; k < 16; k++) begin
      d = '0;
      d[7:0]     = vecs[k].l0;
      d[127:120] = vecs[k].l15;
      applyStimulus(vecs[k].en, vecs[k].valid, vecs[k].win, d);
      checkOutput($sformatf("row_vec%0d", k));
      checkValue($sformatf("row_vec%0d_vld", k), {31'd0, vld_o}, {31'd0, vecs[k].expVld});
      checkValue($sformatf("row_vec%0d_lane0", k), matmul_o[31:0], vecs[k].expL0);
      checkValue($sformatf("row_vec%0d_lane15", k), matmul_o[511:480], vecs[k].expL15);
    end

    // Same row with idle cycles carrying valid_i while en_i is low.
    pulses = 0;
    for (int b = 0; b < 8; b++) begin
      d = '0;
      d[7:0]     = bytes0[b];
      d[127:120] = bytes15[b];
      applyStimulus(1'b1, b == 7, 8'(b + 1), d);
      checkOutput($sformatf("gap_beat%0d", b));
      if (vld_o) pulses++;
      applyStimulus(1'b0, (b % 2) == 0, 8'($urandom), randDin());
      checkOutput($sformatf("gap_idle%0d", b));
      if (vld_o) pulses++;
      if (b == 7) begin
        checkValue("gap_lane0", matmul_o[31:0], 32'd200);
        checkValue("gap_lane15", matmul_o[511:480], 32'd140);
      end
    end
    checkValue("gap_pulses", 32'(pulses), 32'd1);

    // Max operands, back-to-back single-beat closes.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF, {LANES{8'hFF}});
      checkOutput($sformatf("max_b2b%0d", k));
      checkValue($sformatf("max_b2b%0d_vld", k), {31'd0, vld_o}, 32'd1);
      for (int l = 0; l < LANES; l++)
        checkValue($sformatf("max_b2b%0d_lane%0d", k, l), matmul_o[32*l +: 32], maxExp);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, '0);
    checkOutput("max_after");

    // Asynchronous reset in the middle of a row.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'($urandom), randDin());
      checkOutput("midrow_beat");
    end
    #2;
    applyReset();
    checkOutput("async_reset");
    applyStimulus(1'b1, 1'b1, 8'($urandom), randDin());
    checkOutput("async_reset_held");
    rstn_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd3, {LANES{8'h01}});
    checkOutput("post_rst_beat1");
    applyStimulus(1'b1, 1'b1, 8'd4, {LANES{8'h01}});
    checkOutput("post_rst_beat2");
    for (int l = 0; l < LANES; l++)
      checkValue($sformatf("post_rst_lane%0d", l), matmul_o[32*l +: 32], 32'd7);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom), randDin());
      checkOutput($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
